// File: rtl/lcd_hex_driver.sv
// HD44780 character LCD driver: power-up wait, init commands, then continuously
// rewrites line 1 with the 32-bit input word shown as eight uppercase hex digits.
module lcd_hex_driver #(
  parameter int POWERUP_CYCLES = 750000,
  parameter int EN_CYCLES      = 12,
  parameter int CMD_CYCLES     = 2500,
  parameter int CLEAR_CYCLES   = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lcd_data,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        init_done,
  output logic        frame_done
);

  localparam int MAX_A   = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
  localparam int MAX_B   = (MAX_A > CMD_CYCLES) ? MAX_A : CMD_CYCLES;
  localparam int MAX_CNT = (MAX_B > EN_CYCLES) ? MAX_B : EN_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {S_POWERUP, S_INIT, S_SET_ADDR, S_WRITE_CHAR} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  state_t        state;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wait_len;
  logic [1:0]    init_idx;
  logic [2:0]    char_idx;
  logic [31:0]   snapshot;
  logic          last_char;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // Character k shows nibble [31-4k : 28-4k]; {~k,2'b00} is 4*(7-k), its low bit.
  function automatic logic [7:0] char_code(input logic [31:0] word, input logic [2:0] k);
    logic [3:0] n;
    n = word[{~k, 2'b00} +: 4];
    char_code = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Clear-display needs the long settling wait; everything else the short one.
  always_comb begin
    wait_len  = (!LCD_RS && LCD_DATA == 8'h01) ? CW'(CLEAR_CYCLES) : CW'(CMD_CYCLES);
    last_char = (state == S_WRITE_CHAR) && (char_idx == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_POWERUP;
      phase      <= PH_SETUP;
      cnt        <= '0;
      init_idx   <= '0;
      char_idx   <= '0;
      snapshot   <= '0;
      LCD_DATA   <= 8'h00;
      LCD_RS     <= 1'b0;
      LCD_RW     <= 1'b0;
      LCD_EN     <= 1'b0;
      LCD_ON     <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      LCD_ON     <= 1'b1;
      LCD_RW     <= 1'b0;
      frame_done <= 1'b0;
      if (state == S_POWERUP) begin
        if (cnt == CW'(POWERUP_CYCLES)) begin
          state    <= S_INIT;
          phase    <= PH_SETUP;
          init_idx <= 2'd0;
          cnt      <= '0;
          LCD_RS   <= 1'b0;
          LCD_DATA <= init_cmd(2'd0);
          LCD_EN   <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        case (phase)
          PH_SETUP: begin
            phase  <= PH_PULSE;
            LCD_EN <= 1'b1;
            cnt    <= CW'(1);
          end
          PH_PULSE: begin
            if (cnt == CW'(EN_CYCLES)) begin
              phase      <= PH_WAIT;
              LCD_EN     <= 1'b0;
              cnt        <= CW'(1);
              frame_done <= last_char && (CMD_CYCLES == 1);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PH_WAIT: begin
            if (cnt == wait_len) begin
              // Transaction finished: load RS/DATA for the next access's setup cycle.
              phase <= PH_SETUP;
              cnt   <= '0;
              case (state)
                S_INIT: begin
                  if (init_idx == 2'd3) begin
                    state     <= S_SET_ADDR;
                    snapshot  <= lcd_data;
                    init_done <= 1'b1;
                    LCD_RS    <= 1'b0;
                    LCD_DATA  <= 8'h80;
                  end else begin
                    init_idx <= init_idx + 2'd1;
                    LCD_RS   <= 1'b0;
                    LCD_DATA <= init_cmd(init_idx + 2'd1);
                  end
                end
                S_SET_ADDR: begin
                  state    <= S_WRITE_CHAR;
                  char_idx <= 3'd0;
                  LCD_RS   <= 1'b1;
                  LCD_DATA <= char_code(snapshot, 3'd0);
                end
                S_WRITE_CHAR: begin
                  if (char_idx == 3'd7) begin
                    state    <= S_SET_ADDR;
                    snapshot <= lcd_data;
                    char_idx <= 3'd0;
                    LCD_RS   <= 1'b0;
                    LCD_DATA <= 8'h80;
                  end else begin
                    char_idx <= char_idx + 3'd1;
                    LCD_RS   <= 1'b1;
                    LCD_DATA <= char_code(snapshot, char_idx + 3'd1);
                  end
                end
                default: state <= S_POWERUP;
              endcase
            end else begin
              cnt        <= cnt + 1'b1;
              frame_done <= last_char && (cnt == CW'(CMD_CYCLES - 1));
            end
          end
          default: phase <= PH_SETUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Self-checking bench for lcd_hex_driver: every cycle's outputs are compared
// against an expected waveform built from the transaction rules and hex mapping.
module tb_lcd_hex_driver;

  localparam int P   = 10;
  localparam int EN  = 2;
  localparam int CMD = 4;
  localparam int CLR = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lcd_data;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, init_done, frame_done;

  int          checkCount = 0;
  int          passCount  = 0;
  int          failCount  = 0;
  logic [31:0] curData;
  bit          expInit;
  bit          prevEn = 1'b0;
  logic        prevRs;
  logic [7:0]  prevData;

  lcd_hex_driver #(
    .POWERUP_CYCLES(P),
    .EN_CYCLES(EN),
    .CMD_CYCLES(CMD),
    .CLEAR_CYCLES(CLR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lcd_data(lcd_data),
    .LCD_DATA(LCD_DATA),
    .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON),
    .init_done(init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] vec(input logic on, input logic rs, input logic en,
                                      input logic [7:0] d, input logic ini, input logic fd);
    return {on, 1'b0, rs, en, d, ini, fd};
  endfunction

  function automatic logic [7:0] hexAscii(input logic [31:0] word, input int k);
    string digits;
    int    n;
    digits = "0123456789ABCDEF";
    n = int'((word >> (28 - 4 * k)) & 32'hF);
    return digits[n];
  endfunction

  task automatic applyStimulus(input logic r, input logic [31:0] d);
    reset    = r;
    lcd_data = d;
    curData  = d;
  endtask

  // Compares {ON,RW,RS,EN,DATA,init_done,frame_done}; also RS/DATA stability under EN.
  task automatic checkOutput(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    @(negedge clk);
    obs = {LCD_ON, LCD_RW, LCD_RS, LCD_EN, LCD_DATA, init_done, frame_done};
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
    if (prevEn && LCD_EN === 1'b1) begin
      checkCount++;
      assert ({LCD_RS, LCD_DATA} === {prevRs, prevData}) passCount++;
      else begin
        failCount++;
        $error("[TB] FAIL %s stable-under-EN: got %h expected %h", tag,
               {LCD_RS, LCD_DATA}, {prevRs, prevData});
      end
    end
    prevEn   = (LCD_EN === 1'b1);
    prevRs   = LCD_RS;
    prevData = LCD_DATA;
  endtask

  task automatic expectTxn(input string tag, input logic rs, input logic [7:0] data,
                           input int waitLen, input bit lastChar, input int chgAt,
                           input logic [31:0] chgVal);
    int total;
    total = 1 + EN + waitLen;
    for (int c = 0; c < total; c++) begin
      checkOutput($sformatf("%s c%0d", tag, c),
                  vec(1'b1, rs, (c >= 1 && c <= EN), data, expInit, lastChar && (c == total - 1)));
      if (c == chgAt) applyStimulus(1'b0, chgVal);
    end
  endtask

  task automatic runInit();
    expInit = 1'b0;
    for (int i = 0; i < P; i++)
      checkOutput($sformatf("powerup %0d", i), vec(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    expectTxn("init 38", 1'b0, 8'h38, CMD, 1'b0, -1, 32'h0);
    expectTxn("init 0C", 1'b0, 8'h0C, CMD, 1'b0, -1, 32'h0);
    expectTxn("init 06", 1'b0, 8'h06, CMD, 1'b0, -1, 32'h0);
    expectTxn("init 01", 1'b0, 8'h01, CLR, 1'b0, -1, 32'h0);
  endtask

  // Frame shows the word held at SET_ADDR; lcd_data moves to nextVal during char chgChar.
  task automatic runFrame(input string tag, input logic [31:0] nextVal, input int chgChar);
    logic [31:0] frameVal;
    int          at;
    frameVal = curData;
    expInit  = 1'b1;
    expectTxn({tag, " addr"}, 1'b0, 8'h80, CMD, 1'b0, -1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      at = (k == chgChar) ? int'($urandom_range(0, EN + CMD)) : -1;
      expectTxn($sformatf("%s char%0d", tag, k), 1'b1, hexAscii(frameVal, k), CMD,
                k == 7, at, nextVal);
    end
  endtask

  initial begin
    logic [31:0] frameVal;
    applyStimulus(1'b1, 32'h1234ABCD);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("reset state %0d", i), 14'h0);
    applyStimulus(1'b0, 32'h1234ABCD);

    runInit();
    runFrame("hex1234ABCD", 32'h00000000, 5);
    runFrame("zeros", 32'hFFFFFFFF, 6);
    runFrame("ones", 32'h11111111, 0);
    runFrame("pre-switch", 32'h22222222, 3);
    runFrame("post-switch", $urandom, int'($urandom_range(0, 6)));
    for (int f = 0; f < 4; f++)
      runFrame($sformatf("random%0d", f), $urandom, int'($urandom_range(0, 6)));

    // Reset in the middle of character 4's enable pulse.
    frameVal = curData;
    expInit  = 1'b1;
    expectTxn("abort addr", 1'b0, 8'h80, CMD, 1'b0, -1, 32'h0);
    for (int k = 0; k < 4; k++)
      expectTxn($sformatf("abort char%0d", k), 1'b1, hexAscii(frameVal, k), CMD, 1'b0, -1, 32'h0);
    checkOutput("abort char4 setup", vec(1'b1, 1'b1, 1'b0, hexAscii(frameVal, 4), 1'b1, 1'b0));
    checkOutput("abort char4 pulse", vec(1'b1, 1'b1, 1'b1, hexAscii(frameVal, 4), 1'b1, 1'b0));
    applyStimulus(1'b1, 32'hC0FFEE59);
    checkOutput("reset mid-pulse", 14'h0);
    checkOutput("reset held", 14'h0);
    applyStimulus(1'b0, 32'hC0FFEE59);
    runInit();
    runFrame("after-reset", $urandom, 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lcd_hex_driver.md
LCD_HEX_DRIVER -- requirements
Module: lcd_hex_driver

Interface
REQ-001 Parameter POWERUP_CYCLES, default 750000, SHALL set the idle wait after reset before the first command (15 ms at 50 MHz).
REQ-002 Parameter EN_CYCLES, default 12, SHALL set the width of the LCD_EN high pulse in clocks.
REQ-003 Parameter CMD_CYCLES, default 2500, SHALL set the post-pulse wait for ordinary commands and character writes.
REQ-004 Parameter CLEAR_CYCLES, default 82000, SHALL set the post-pulse wait for the clear-display command.
REQ-005 clk  in  1  single system clock; all state SHALL change on its rising edge only.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 lcd_data  in  32  word to display as 8 hex characters.
REQ-008 LCD_DATA  out  8  HD44780 data bus.
REQ-009 LCD_RS  out  1  0 = command, 1 = character data.
REQ-010 LCD_RW  out  1  SHALL be held at 0 (write only).
REQ-011 LCD_EN  out  1  LCD enable strobe.
REQ-012 LCD_ON  out  1  panel power; 0 in reset, 1 otherwise.
REQ-013 init_done  out  1  high once the init sequence completes, until next reset.
REQ-014 frame_done  out  1  one-cycle pulse when the 8th character write finishes.

Function
REQ-015 Every LCD access SHALL be a transaction:
- 1 setup cycle: RS/DATA driven, EN=0.
- EN_CYCLES cycles with EN=1.
- Wait cycles with EN=0: CLEAR_CYCLES for command 0x01, CMD_CYCLES otherwise.
- RS/DATA held stable for the whole transaction.
REQ-016 States SHALL be: POWERUP -> INIT -> SET_ADDR -> WRITE_CHAR -> SET_ADDR (loop).
REQ-017 POWERUP SHALL wait POWERUP_CYCLES cycles with EN=0, then enter INIT.
REQ-018 INIT SHALL issue commands 0x38, 0x0C, 0x06, 0x01 in order, RS=0.
REQ-019 init_done SHALL rise in the cycle SET_ADDR is first entered.
REQ-020 SET_ADDR SHALL sample lcd_data into a 32-bit snapshot register and issue command 0x80 (line 1, column 0), RS=0.
REQ-021 WRITE_CHAR SHALL issue 8 data writes, RS=1, index 0..7.
- Character k uses snapshot nibble [31-4k : 28-4k] (MSB first).
REQ-022 Nibble-to-ASCII mapping SHALL be:
- n 0..9 -> 0x30+n.
- n 10..15 -> 0x37+n (uppercase 'A'..'F').
REQ-023 frame_done SHALL pulse in the last wait cycle of character 7; SET_ADDR SHALL follow on the next cycle.
REQ-024 Changes on lcd_data during a frame SHALL NOT affect that frame; they appear in the next frame.
REQ-025 Cycle counters SHALL be wide enough for max(POWERUP_CYCLES, CLEAR_CYCLES) with no wrap.
REQ-026 The character index SHALL wrap 7 -> 0 only through SET_ADDR.

Reset
REQ-027 reset=1 SHALL, on the next clock edge, force the following, regardless of current state or mid-pulse EN:
- state POWERUP, all counters and the snapshot 0.
- LCD_DATA=0x00, LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_ON=0.
- init_done=0, frame_done=0.
REQ-028 After reset deasserts, the full POWERUP and INIT sequence SHALL rerun; no partial transaction SHALL resume.

Verification (params POWERUP=10, EN=2, CMD=4, CLEAR=8)
REQ-029 Reset release -> EN stays 0 for 10 cycles.
- Then commands 0x38, 0x0C, 0x06, 0x01 follow, each EN high exactly 2 cycles.
- Waits after them are 4, 4, 4, 8 cycles.
REQ-030 lcd_data=0x1234ABCD -> after 0x80, data bytes are 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 with RS=1; frame_done pulses once.
REQ-031 lcd_data=0x00000000 -> eight 0x30 writes; lcd_data=0xFFFFFFFF -> eight 0x46 writes.
REQ-032 lcd_data switches 0x11111111 -> 0x22222222 after the 3rd character -> current frame all 0x31, next frame all 0x32.
REQ-033 reset asserted while EN=1 during character 4 -> next cycle EN=0, LCD_ON=0, init_done=0; the POWERUP wait then restarts from 0.
REQ-034 Throughout all scenarios, LCD_RW=0 always and RS/DATA never change while EN=1 (checked by assertion).
